// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy button/physics front end.
// Holds the button FSM states, clock-derived defaults and the flap pending-flag rule.
package flappy_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int CLK_HZ      = 25_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int REPEAT_MS   = 250;

  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEFAULT_REPEAT_CYCLES   = (CLK_HZ / 1000) * REPEAT_MS;
  localparam int DEFAULT_CNT_W           = 24;

  // frame_tick is a one-cycle strobe marking the cycle the physics block samples flap_btn;
  // a pending flap is consumed only by a tick that sees it high.
  function automatic logic frame_consumes(input logic tick, input logic pend);
    return tick & pend;
  endfunction

  // A new press wins over consumption so two flaps are never merged into one.
  function automatic logic next_pending(input logic evt, input logic tick, input logic pend);
    if (evt) return 1'b1;
    if (frame_consumes(tick, pend)) return 1'b0;
    return pend;
  endfunction

endpackage

// File: rtl/flap_input_conditioner_bit_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Reused by every board push-button input.
module bit_sync
  import flappy_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/flap_input_conditioner.sv
// Button synchroniser, debouncer and flap-request holder feeding the physics flap_btn input.
// Optional macro FLAP_AUTOREPEAT_EN adds periodic press events while the button stays held.
module flap_input_conditioner
  import flappy_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  input  logic frame_tick,
  output logic flap_req,
  output logic btn_level,
  output logic overrun
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1 ||
      longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W) ||
      longint'(REPEAT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_cfg
    $error("flap_input_conditioner: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             btn_s;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             press_deb;
  logic             press_evt;

  bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (btn_raw),
    .q       (btn_s)
  );

  // Debounce FSM: a level change is accepted after DEBOUNCE_CYCLES consecutive stable samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RELEASED;
      cnt       <= '0;
      btn_level <= 1'b0;
      press_deb <= 1'b0;
    end else begin
      press_deb <= 1'b0;
      case (state)
        RELEASED: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt + CNT_ONE == DEB_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            btn_level <= 1'b1;
            press_deb <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt + CNT_ONE == DEB_LAST) begin
            state     <= RELEASED;
            cnt       <= '0;
            btn_level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= RELEASED;
          cnt       <= '0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

`ifdef FLAP_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_evt;

  // Repeat timer only advances while the button is steadily held; any other cycle restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt <= '0;
      rpt_evt <= 1'b0;
    end else begin
      rpt_evt <= 1'b0;
      if (state == HELD && btn_s) begin
        if (rpt_cnt == RPT_LAST) begin
          rpt_cnt <= '0;
          rpt_evt <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + CNT_ONE;
        end
      end else begin
        rpt_cnt <= '0;
      end
    end
  end

  assign press_evt = press_deb | rpt_evt;
`else
  assign press_evt = press_deb;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flap_req <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      flap_req <= next_pending(press_evt, frame_tick, flap_req);
      overrun  <= press_evt & flap_req & ~frame_tick;
    end
  end

endmodule
